// File: rtl/immgen_pkg.sv
// ============================================================================
// Module : immgen_pkg -- opcodes, format codes and buffer states for immgen_pipe
// Rev    : 1.0
// ============================================================================
`default_nettype none

package immgen_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } buf_state_t;

    // CSRRWI / CSRRSI / CSRRCI carry a 5-bit zimm in the rs1 field
    function automatic logic is_csr_imm(input logic [2:0] funct3);
        return (funct3 == 3'b101) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

`default_nettype wire

// File: rtl/immgen_pipe_if.sv
// ============================================================================
// Module : immgen_pipe_if -- upstream/downstream handshake bundle of immgen_pipe
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface immgen_pipe_if #(
    parameter int XLEN = 32
) ();
    import immgen_pkg::*;

    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instr;
    logic            o_valid;
    logic            i_ready;
    logic [31:0]     o_instr;
    logic [XLEN-1:0] o_imm;
    imm_fmt_t        o_fmt;

    modport slave (
        input  i_valid,
        input  i_instr,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_instr,
        output o_imm,
        output o_fmt
    );

    modport master (
        output i_valid,
        output i_instr,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_instr,
        input  o_imm,
        input  o_fmt
    );

endinterface

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// Module : imm_decode -- combinational RV32I immediate decoder (I/S/B/U/J/Z)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_decode
    import immgen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit ZICSR = 1'b1
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_t        o_fmt
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = 32'h0;
        o_fmt   = FMT_NONE;
        case (i_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {i_instr[31:12], 12'h000};
                o_fmt   = FMT_U;
            end
            OP_JAL: begin
                w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
                o_fmt   = FMT_J;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                o_fmt   = FMT_I;
            end
            OP_STORE: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                o_fmt   = FMT_S;
            end
            OP_BRANCH: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
                o_fmt   = FMT_B;
            end
            OP_SYSTEM: begin
                if (ZICSR && is_csr_imm(i_instr[14:12])) begin
                    w_imm32 = {27'h0, i_instr[19:15]};
                    o_fmt   = FMT_Z;
                end
            end
            default: begin
                w_imm32 = 32'h0;
                o_fmt   = FMT_NONE;
            end
        endcase
    end

    // Bit 31 of the 32-bit result already holds the correct fill bit for every format
    if (XLEN > 32) begin : g_ext_wide
        assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_ext_native
        assign o_imm = w_imm32[XLEN-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/immgen_pipe.sv
// ============================================================================
// Module : immgen_pipe -- registered immediate-generation stage, 2-entry skid
// Rev    : 1.0
// ============================================================================
`default_nettype none

module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit ZICSR = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    immgen_pipe_if.slave bus
);

    logic [XLEN-1:0] w_dec_imm;
    imm_fmt_t        w_dec_fmt;
    logic            w_in_acc;
    logic            w_out_acc;

    buf_state_t      state_q,      state_d;
    logic [31:0]     main_instr_q, main_instr_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    imm_fmt_t        main_fmt_q,   main_fmt_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    imm_fmt_t        skid_fmt_q,   skid_fmt_d;

    imm_decode #(
        .XLEN  (XLEN),
        .ZICSR (ZICSR)
    ) u_decode (
        .i_instr (bus.i_instr),
        .o_imm   (w_dec_imm),
        .o_fmt   (w_dec_fmt)
    );

    // Both handshake outputs depend only on state_q, so i_ready never reaches o_ready
    assign bus.o_valid = (state_q != ST_EMPTY);
    assign bus.o_ready = (state_q != ST_FULL2);
    assign bus.o_instr = main_instr_q;
    assign bus.o_imm   = main_imm_q;
    assign bus.o_fmt   = main_fmt_q;

    assign w_in_acc  = bus.i_valid & bus.o_ready;
    assign w_out_acc = bus.o_valid & bus.i_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_imm_d   = main_imm_q;
        main_fmt_d   = main_fmt_q;
        skid_instr_d = skid_instr_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_in_acc) begin
                    main_instr_d = bus.i_instr;
                    main_imm_d   = w_dec_imm;
                    main_fmt_d   = w_dec_fmt;
                    state_d      = ST_FULL1;
                end
            end
            ST_FULL1: begin
                if (w_in_acc && w_out_acc) begin
                    main_instr_d = bus.i_instr;
                    main_imm_d   = w_dec_imm;
                    main_fmt_d   = w_dec_fmt;
                end else if (w_in_acc) begin
                    skid_instr_d = bus.i_instr;
                    skid_imm_d   = w_dec_imm;
                    skid_fmt_d   = w_dec_fmt;
                    state_d      = ST_FULL2;
                end else if (w_out_acc) begin
                    state_d      = ST_EMPTY;
                end
            end
            ST_FULL2: begin
                if (w_out_acc) begin
                    main_instr_d = skid_instr_q;
                    main_imm_d   = skid_imm_q;
                    main_fmt_d   = skid_fmt_q;
                    state_d      = ST_FULL1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Branch redirect: drop everything, including this cycle's input
        if (i_flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = 32'h0;
            main_imm_d   = '0;
            main_fmt_d   = FMT_NONE;
            skid_instr_d = 32'h0;
            skid_imm_d   = '0;
            skid_fmt_d   = FMT_NONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= 32'h0;
            main_imm_q   <= '0;
            main_fmt_q   <= FMT_NONE;
            skid_instr_q <= 32'h0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_imm_q   <= main_imm_d;
            main_fmt_q   <= main_fmt_d;
            skid_instr_q <= skid_instr_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_immgen_pipe.sv
// ============================================================================
// Module : tb_immgen_pipe -- two configurations (32/Zicsr, 64/no Zicsr) in lockstep
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_immgen_pipe;

    logic clk;
    logic rst;
    logic flush;
    int   n_total;
    int   n_bad;
    logic [31:0] mq[$];

    immgen_pipe_if #(.XLEN(32)) bus32 ();
    immgen_pipe_if #(.XLEN(64)) bus64 ();

    immgen_pipe #(.XLEN(32), .ZICSR(1'b1)) u_dut32 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus32)
    );

    immgen_pipe #(.XLEN(64), .ZICSR(1'b0)) u_dut64 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] ins, input bit zicsr,
                                    output logic [63:0] imm, output logic [2:0] fmt);
        longint v;
        v   = 0;
        fmt = 3'd0;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin
                v = longint'($signed({ins[31:12], 12'h000}));      fmt = 3'd4;
            end
            7'b1101111: begin
                v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); fmt = 3'd5;
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                v = longint'($signed(ins[31:20]));                 fmt = 3'd1;
            end
            7'b0100011: begin
                v = longint'($signed({ins[31:25], ins[11:7]}));    fmt = 3'd2;
            end
            7'b1100011: begin
                v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); fmt = 3'd3;
            end
            7'b1110011: begin
                if (zicsr && ins[14:12] >= 3'd5) begin
                    v = longint'({59'h0, ins[19:15]});             fmt = 3'd6;
                end
            end
            default: ;
        endcase
        imm = 64'(v);
    endfunction

    task automatic check_outputs();
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        check("valid32", 64'(bus32.o_valid), 64'(mq.size() > 0));
        check("ready32", 64'(bus32.o_ready), 64'(mq.size() < 2));
        check("valid64", 64'(bus64.o_valid), 64'(mq.size() > 0));
        check("ready64", 64'(bus64.o_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            ref_dec(mq[0], 1'b1, e_imm, e_fmt);
            check("instr32", 64'(bus32.o_instr), 64'(mq[0]));
            check("imm32",   64'(bus32.o_imm),   {32'h0, e_imm[31:0]});
            check("fmt32",   64'(bus32.o_fmt),   64'(e_fmt));
            ref_dec(mq[0], 1'b0, e_imm, e_fmt);
            check("instr64", 64'(bus64.o_instr), 64'(mq[0]));
            check("imm64",   64'(bus64.o_imm),   e_imm);
            check("fmt64",   64'(bus64.o_fmt),   64'(e_fmt));
        end
    endtask

    // Apply one cycle of inputs, advance the FIFO model, then check after the edge
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic fl, input logic rs);
        bit in_acc, out_acc;
        bus32.i_valid = v;   bus64.i_valid = v;
        bus32.i_instr = ins; bus64.i_instr = ins;
        bus32.i_ready = rdy; bus64.i_ready = rdy;
        flush = fl;
        rst   = rs;
        in_acc  = v && (mq.size() < 2);
        out_acc = rdy && (mq.size() > 0);
        if (rs || fl) begin
            mq.delete();
        end else begin
            if (out_acc) void'(mq.pop_front());
            if (in_acc)  mq.push_back(ins);
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                7'b0010011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0101011};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    logic [31:0] sw_ins [8];
    logic [31:0] sw_e32 [8];
    logic [2:0]  sw_f32 [8];
    logic [63:0] sw_e64 [8];
    logic [2:0]  sw_f64 [8];

    initial begin
        n_total = 0;
        n_bad   = 0;
        sw_ins = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                   32'h001000EF, 32'h300FD073, 32'h0000007F, 32'h00000000};
        sw_e32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                   32'h00000800, 32'h0000001F, 32'h00000000, 32'h00000000};
        sw_f32 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
        sw_e64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                   64'h0000000012345000, 64'h0000000000000800, 64'h0,
                   64'h0, 64'h0};
        sw_f64 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0};

        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_valid", 64'(bus32.o_valid), 64'd0);
        check("rst_ready", 64'(bus32.o_ready), 64'd1);
        check("rst_instr", 64'(bus32.o_instr), 64'd0);
        check("rst_imm",   64'(bus64.o_imm),   64'd0);
        check("rst_fmt",   64'(bus32.o_fmt),   64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Format sweep, back-to-back at full throughput
        for (int i = 0; i < 7; i++) begin
            step(1'b1, sw_ins[i], 1'b1, 1'b0, 1'b0);
            check("sweep_imm32", 64'(bus32.o_imm), {32'h0, sw_e32[i]});
            check("sweep_fmt32", 64'(bus32.o_fmt), 64'(sw_f32[i]));
            check("sweep_imm64", 64'(bus64.o_imm), sw_e64[i]);
            check("sweep_fmt64", 64'(bus64.o_fmt), 64'(sw_f64[i]));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A, B accepted, C held; then drain in order
        step(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 1'b0, 1'b0, 1'b0);
        check("bp_ready", 64'(bus32.o_ready), 64'd0);
        step(1'b1, 32'h00300093, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 1'b0, 1'b0, 1'b0);
        check("bp_hold", 64'(bus32.o_instr), 64'h00100093);
        step(1'b1, 32'h00300093, 1'b1, 1'b0, 1'b0);
        check("bp_second", 64'(bus32.o_instr), 64'h00200093);
        step(1'b1, 32'h00300093, 1'b1, 1'b0, 1'b0);
        check("bp_third", 64'(bus32.o_instr), 64'h00300093);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush in FULL2 with a live input
        step(1'b1, 32'h00400093, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00600093, 1'b0, 1'b1, 1'b0);
        check("fl_valid", 64'(bus32.o_valid), 64'd0);
        check("fl_ready", 64'(bus64.o_ready), 64'd1);
        step(1'b1, 32'h00700093, 1'b1, 1'b0, 1'b0);
        check("fl_next", 64'(bus32.o_instr), 64'h00700093);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset while in FULL2
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFE112E23, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h123452B7, 1'b0, 1'b0, 1'b1);
        check("mr_valid", 64'(bus32.o_valid), 64'd0);
        check("mr_ready", 64'(bus32.o_ready), 64'd1);
        check("mr_imm",   64'(bus32.o_imm),   64'd0);
        check("mr_fmt",   64'(bus64.o_fmt),   64'd0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/immgen_pipe.md
# immgen_pipe

Parametrised, registered immediate-generation stage for the RV32I core's decode path. Accepts one instruction per cycle over a valid/ready handshake and decodes all base formats (I, S, B, U, J), plus the optional Zicsr 5-bit zimm. Sign-extends the immediate to XLEN and presents it one cycle later through a two-entry skid buffer. Sits between fetch/IF-ID and the register-read stage; flushed on branch redirect.

## Interface
- XLEN, 32: immediate output width; legal values are 32 or 64. Sign extension fills to XLEN.
- ZICSR, 1: 1 = decode SYSTEM CSR-immediate forms as format Z; 0 = treat them as FMT_NONE.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  synchronous clear of all buffered entries.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; registered.
- i_instr  in  32  instruction word.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_instr  out  32  instruction passed through with its immediate.
- o_imm  out  XLEN  decoded immediate.
- o_fmt  out  3  format code of type imm_fmt_t.

## Operation
- Decode on opcode i_instr[6:0]:
  - LUI 0110111 and AUIPC 0010111 → U = {instr[31:12], 12'b0}.
  - JAL 1101111 → J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011 → I = instr[31:20].
    - Shift forms keep the raw 12 bits.
  - STORE 0100011 → S = {instr[31:25], instr[11:7]}.
  - BRANCH 1100011 → B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - SYSTEM 1110011 with funct3 ∈ {101, 110, 111} and ZICSR=1 → Z = zero-extended instr[19:15].
  - Anything else → imm = 0, fmt = FMT_NONE.
- I, S, B, U and J are sign-extended from instr[31] to XLEN. Z is zero-extended.
- Storage is two registered entries, MAIN (drives the outputs) and SKID.
- Input accept = i_valid & o_ready. Output accept = o_valid & i_ready.
- Buffer state machine:
  - EMPTY:
    - accept → FULL1.
  - FULL1:
    - output accept without input accept → EMPTY.
    - input accept with output accept → FULL1; MAIN is replaced.
    - input accept without output accept → FULL2; the new entry goes to SKID.
  - FULL2:
    - output accept → FULL1; SKID moves to MAIN.
    - No input is accepted in FULL2.
- o_ready = 1 exactly when the state is not FULL2. It is a register-derived signal, with no combinational path from i_ready.
- i_flush:
  - Next state is EMPTY and both entries are invalidated.
  - The input in that cycle is dropped, even if o_ready was high.
  - Flush has priority over every simultaneous accept.
- Reset and flush take priority over everything, including mid-operation.
  - After reset: o_valid=0, o_ready=1, o_instr=0, o_imm=0, o_fmt=FMT_NONE.
- While o_valid=1 and i_ready=0, o_instr, o_imm and o_fmt hold stable.

## Timing
- Latency: an instruction accepted at edge N is presented on the outputs after edge N; sampled by downstream at edge N+1 or later.
- Throughput: 1 instruction per cycle when i_ready is held high.
- Under backpressure, at most 2 entries are held. o_ready falls the cycle after the second one is accepted.
- Ordering is strict FIFO; no reordering or duplication.
- Flush at edge N: o_valid=0 after N. A new input can be accepted at edge N+1.

## Structure
- Package immgen_pkg holds:
  - opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_SYSTEM;
  - imm_fmt_t enum, 3 bits: FMT_NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6;
  - buffer state enum.
- Combinational sub-module imm_decode, parametrised by XLEN and ZICSR: i_instr → imm, fmt.
  - immgen_pipe instantiates it once, on the input side.
  - The skid logic lives in immgen_pipe.

## Test plan
- Format sweep, XLEN=32, i_ready=1:
  - 0xFFF00093 → imm 0xFFFFFFFF, FMT I.
  - 0xFE112E23 → 0xFFFFFFFC, S.
  - 0xFE000CE3 → 0xFFFFFFF8, B.
  - 0x123452B7 → 0x12345000, U.
  - 0x001000EF → 0x00000800, J.
  - Each appears one cycle after acceptance.
- Zicsr: 0x300FD073 → 0x0000001F, FMT Z with ZICSR=1; imm 0, FMT_NONE with ZICSR=0.
- XLEN=64: 0xFFF00093 → 0xFFFFFFFFFFFFFFFF; 0x123452B7 → 0x0000000012345000.
- Backpressure:
  - Hold i_ready=0 and offer A, B, C back-to-back.
  - A and B are accepted, o_ready drops, C is held.
  - Raise i_ready: outputs A, B, C in order, one per cycle.
  - Outputs stay stable while stalled.
- Flush in FULL2 with i_valid=1 in the same cycle:
  - Next cycle o_valid=0 and o_ready=1.
  - The flushed-cycle input never appears.
  - The next instruction passes normally.
- Reset mid-stream, asserted in FULL2: next cycle o_valid=0, o_ready=1, o_imm=0, o_fmt=FMT_NONE.
- Unknown opcode 0x0000007F → imm 0, FMT_NONE.
